// File: rtl/mux_4to1_16b_pkg.sv
// ---------------------------------------------------------------------------
// mux_4to1_16b_pkg
// Shared definitions for the stack-machine datapath word selectors.
//   SEL_A..SEL_D   : select codes that route A/B/C/D onto the selector output
//   SEL_WIDTH      : width of a select code
//   DEFAULT_WIDTH  : default datapath word width
//   selToOnehot()  : decode of a select code into a 4-bit one-hot vector
// ---------------------------------------------------------------------------
package mux_4to1_16b_pkg;

    localparam int SEL_WIDTH     = 2;
    localparam int DEFAULT_WIDTH = 16;

    localparam logic [SEL_WIDTH-1:0] SEL_A = 2'd0;
    localparam logic [SEL_WIDTH-1:0] SEL_B = 2'd1;
    localparam logic [SEL_WIDTH-1:0] SEL_C = 2'd2;
    localparam logic [SEL_WIDTH-1:0] SEL_D = 2'd3;

    // Unknown select codes decode to no bit set, so downstream consumers of
    // the one-hot vector never see a stale or guessed lane.
    function automatic logic [3:0] selToOnehot(input logic [SEL_WIDTH-1:0] sel);
        logic [3:0] decoded;
        decoded = 4'b0000;
        case (sel)
            SEL_A:   decoded = 4'b0001;
            SEL_B:   decoded = 4'b0010;
            SEL_C:   decoded = 4'b0100;
            SEL_D:   decoded = 4'b1000;
            default: decoded = 4'b0000;
        endcase
        return decoded;
    endfunction

endpackage

// File: rtl/mux_4to1_16b_mux2.sv
// ---------------------------------------------------------------------------
// mux2_16b
// Parameterised two-input word multiplexer, the leaf cell of the 4:1 tree.
//   WIDTH  : data width
//   sel    : in,  1      0 selects a, 1 selects b
//   a, b   : in,  WIDTH  candidate words
//   y      : out, WIDTH  selected word (combinational)
// ---------------------------------------------------------------------------
module mux2_16b
    import mux_4to1_16b_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             sel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    // A case statement rather than a ternary: an unknown select then drives
    // the whole word to X in simulation instead of merging the bits where a
    // and b happen to agree, which would hide a broken control path.
    always_comb begin
        y = '0;
        case (sel)
            1'b0:    y = a;
            1'b1:    y = b;
            default: y = 'x;
        endcase
    end

endmodule

// File: rtl/mux_4to1_16b.sv
// ---------------------------------------------------------------------------
// mux_4to1_16b
// Four-input word selector for the stack-machine operand/result buses, with
// a combinational output and a registered copy for pipelined consumers.
//   WIDTH    : data width of A, B, C, D, Y and Y_q
//   CLK      : in,  1      rising-edge system clock
//   Reset    : in,  1      synchronous active-high reset of Y_q/sel_q
//   A..D     : in,  WIDTH  input words for select codes 0..3
//   control  : in,  2      select code
//   en       : in,  1      load enable for Y_q/sel_q
//   Y        : out, WIDTH  combinational selected word
//   Y_q      : out, WIDTH  registered selected word
//   sel_q    : out, 2      select code captured with Y_q
//   onehot   : out, 4      combinational one-hot decode of control
// ---------------------------------------------------------------------------
module mux_4to1_16b
    import mux_4to1_16b_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 CLK,
    input  logic                 Reset,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    input  logic [WIDTH-1:0]     C,
    input  logic [WIDTH-1:0]     D,
    input  logic [SEL_WIDTH-1:0] control,
    input  logic                 en,
    output logic [WIDTH-1:0]     Y,
    output logic [WIDTH-1:0]     Y_q,
    output logic [SEL_WIDTH-1:0] sel_q,
    output logic [3:0]           onehot
);

    logic [WIDTH-1:0] lowPair;
    logic [WIDTH-1:0] highPair;

    // First level picks within each pair on control[0]; the second level
    // picks between the pairs on control[1]. Y therefore has no clock or
    // reset dependence and follows its inputs in the same cycle.
    mux2_16b #(.WIDTH(WIDTH)) muxLow (
        .sel (control[0]),
        .a   (A),
        .b   (B),
        .y   (lowPair)
    );

    mux2_16b #(.WIDTH(WIDTH)) muxHigh (
        .sel (control[0]),
        .a   (C),
        .b   (D),
        .y   (highPair)
    );

    mux2_16b #(.WIDTH(WIDTH)) muxFinal (
        .sel (control[1]),
        .a   (lowPair),
        .b   (highPair),
        .y   (Y)
    );

    // One-hot view of the select code for hazard and debug logic.
    always_comb begin
        onehot = selToOnehot(control);
    end

    // Registered copy of the selected word and its select code. Reset wins
    // over en; with en low both registers simply hold their last value.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            Y_q   <= '0;
            sel_q <= SEL_A;
        end else if (en) begin
            Y_q   <= Y;
            sel_q <= control;
        end
    end

endmodule

// File: tb/tb_mux_4to1_16b.sv
// ---------------------------------------------------------------------------
// tb_mux_4to1_16b
// Self-checking bench for mux_4to1_16b: directed scenarios plus randomized
// traffic compared against a behavioural model that indexes an array of the
// four input words and tracks the registered path at each rising edge.
// ---------------------------------------------------------------------------
module tb_mux_4to1_16b;

    logic        CLK;
    logic        Reset;
    logic [15:0] A, B, C, D;
    logic [1:0]  control;
    logic        en;
    logic [15:0] Y;
    logic [15:0] Y_q;
    logic [1:0]  sel_q;
    logic [3:0]  onehot;

    int checkCount = 0;
    int errorCount = 0;

    // Model state for the registered outputs
    logic [15:0] expYq;
    logic [1:0]  expSel;

    mux_4to1_16b #(.WIDTH(16)) dut (
        .CLK     (CLK),
        .Reset   (Reset),
        .A       (A),
        .B       (B),
        .C       (C),
        .D       (D),
        .control (control),
        .en      (en),
        .Y       (Y),
        .Y_q     (Y_q),
        .sel_q   (sel_q),
        .onehot  (onehot)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Reference selection: the four words as an array indexed by control.
    function automatic logic [15:0] refSelect(input logic [15:0] a, input logic [15:0] b,
                                              input logic [15:0] c, input logic [15:0] d,
                                              input logic [1:0] ctl);
        logic [15:0] words [4];
        words[0] = a;
        words[1] = b;
        words[2] = c;
        words[3] = d;
        return words[ctl];
    endfunction

    function automatic logic [3:0] refOnehot(input logic [1:0] ctl);
        return 4'(1) << ctl;
    endfunction

    // Inputs only change on the falling edge, so at each rising edge the
    // model sees exactly the values the DUT samples.
    always @(posedge CLK) begin
        if (Reset) begin
            expYq  = 16'h0000;
            expSel = 2'd0;
        end else if (en) begin
            expYq  = refSelect(A, B, C, D, control);
            expSel = control;
        end
    end

    task automatic checkOutput(input string tag, input logic [15:0] actual, input logic [15:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b,
                                 input logic [15:0] c, input logic [15:0] d,
                                 input logic [1:0] ctl, input logic enV, input logic rstV);
        @(negedge CLK);
        A = a; B = b; C = c; D = d;
        control = ctl;
        en      = enV;
        Reset   = rstV;
        #1;
    endtask

    task automatic checkComb(input string tag);
        checkOutput({tag, "_Y"}, Y, refSelect(A, B, C, D, control));
        checkOutput({tag, "_onehot"}, {12'h000, onehot}, {12'h000, refOnehot(control)});
    endtask

    task automatic checkRegs(input string tag);
        @(posedge CLK);
        #1;
        checkOutput({tag, "_Y_q"}, Y_q, expYq);
        checkOutput({tag, "_sel_q"}, {14'h0, sel_q}, {14'h0, expSel});
    endtask

    initial begin
        Reset = 1'b1; en = 1'b0; control = 2'd0;
        A = '0; B = '0; C = '0; D = '0;

        // Reset state
        checkRegs("reset");
        checkOutput("reset_Y_q_zero", Y_q, 16'h0000);
        checkOutput("reset_sel_q_zero", {14'h0, sel_q}, 16'h0000);

        // Exhaustive sweep of control against small distinct data values
        for (int ctl = 0; ctl < 4; ctl++)
            for (int bits = 0; bits < 16; bits++) begin
                applyStimulus(16'(0 + bits[0]), 16'(2 + bits[1]), 16'(4 + bits[2]),
                              16'(6 + bits[3]), 2'(ctl), 1'b0, 1'b0);
                checkComb("sweep");
            end

        // Y follows control without any clock edge
        applyStimulus(16'hFFFF, 16'h0000, 16'hAAAA, 16'h5555, 2'd3, 1'b0, 1'b0);
        checkOutput("noclk_before", Y, 16'h5555);
        control = 2'd0;
        #1;
        checkOutput("noclk_after", Y, 16'hFFFF);

        // Load a nonzero value so the following reset has something to clear
        applyStimulus(16'h0000, 16'h0000, 16'h0000, 16'h7777, 2'd3, 1'b1, 1'b0);
        checkRegs("preload");
        checkOutput("preload_Y_q", Y_q, 16'h7777);

        // Reset has priority over en; Y keeps tracking its inputs
        applyStimulus(16'h0000, 16'h0000, 16'h1234, 16'h0000, 2'd2, 1'b1, 1'b1);
        checkRegs("midreset");
        checkOutput("midreset_Y_q", Y_q, 16'h0000);
        checkOutput("midreset_sel_q", {14'h0, sel_q}, 16'h0000);
        checkOutput("midreset_Y", Y, 16'h1234);

        // Load then hold
        applyStimulus(16'h0000, 16'hBEEF, 16'h0000, 16'h0000, 2'd1, 1'b1, 1'b0);
        checkRegs("load");
        checkOutput("load_Y_q", Y_q, 16'hBEEF);
        checkOutput("load_sel_q", {14'h0, sel_q}, 16'h0001);
        applyStimulus(16'h0000, 16'h0001, 16'h0000, 16'h0000, 2'd1, 1'b0, 1'b0);
        checkOutput("hold_Y", Y, 16'h0001);
        checkRegs("hold");
        checkOutput("hold_Y_q", Y_q, 16'hBEEF);

        // One-hot decode
        for (int ctl = 0; ctl < 4; ctl++) begin
            applyStimulus(16'h1111, 16'h2222, 16'h3333, 16'h4444, 2'(ctl), 1'b0, 1'b0);
            checkOutput("onehot_direct", {12'h000, onehot}, 16'(1 << ctl));
        end

        // Randomized traffic, including equal and all-zero words
        for (int i = 0; i < 300; i++) begin
            logic [15:0] ra, rb, rc, rd;
            ra = 16'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? ra : 16'($urandom);
            rc = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
            rd = 16'($urandom);
            applyStimulus(ra, rb, rc, rd, 2'($urandom_range(0, 3)),
                          1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));
            checkComb("rand");
            checkRegs("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
